fir_x_scheduler: RTL and testbench

FIR_X_SCHEDULER -- requirements
Module: fir_x_scheduler

---
 rtl/fir_x_scheduler_pkg.sv | 22 ++
 rtl/fir_x_scheduler_line_counter.sv | 55 +++++
 rtl/fir_x_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_fir_x_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_x_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fir_x_scheduler_pkg
// Brief   : Shared FIR constants and the x-scheduler state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package fir_x_scheduler_pkg;

  // Largest horizontal decimation factor supported by the FIR datapath
  localparam int FIR_MAX_FACTOR   = 7;
  localparam int FIR_MAX_FACTOR_W = $clog2(FIR_MAX_FACTOR + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_HOLD  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_CLEAR = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/fir_x_scheduler_line_counter.sv
`default_nettype none
// ============================================================================
// Module  : line_counter
// Brief   : Column / line position tracker for the x scheduler.
// Revision: 1.0 - initial release
// ============================================================================
module line_counter #(
  parameter int WIDTH_W  = 12,
  parameter int HEIGHT_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                adv,
  input  logic [WIDTH_W-1:0]  width,
  input  logic [HEIGHT_W-1:0] height,
  output logic                col_last,
  output logic                line_last
);

  logic [WIDTH_W-1:0]  col_q,  col_d;
  logic [HEIGHT_W-1:0] line_q, line_d;

  // Position flags and next-position logic; column wraps at line end
  always_comb begin
    col_last  = (col_q == width - WIDTH_W'(1));
    line_last = (line_q == height - HEIGHT_W'(1));
    col_d     = col_q;
    line_d    = line_q;
    if (clr) begin
      col_d  = '0;
      line_d = '0;
    end else if (adv) begin
      if (col_last) begin
        col_d  = '0;
        line_d = line_last ? '0 : line_q + HEIGHT_W'(1);
      end else begin
        col_d = col_q + WIDTH_W'(1);
      end
    end
  end

  // Position registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      line_q <= '0;
    end else begin
      col_q  <= col_d;
      line_q <= line_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_x_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : fir_x_scheduler
// Brief   : Sequences pixel groups of D samples into the FIR phase registers,
//           strobes the FIR output latch and manages the output handshake.
// Revision: 1.0 - initial release
// ============================================================================
module fir_x_scheduler
  import fir_x_scheduler_pkg::*;
#(
  parameter int MAX_FACTOR = FIR_MAX_FACTOR,
  parameter int WIDTH_W    = 12,
  parameter int HEIGHT_W   = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  input  logic [2:0]          cfg_factor,
  input  logic [WIDTH_W-1:0]  cfg_width,
  input  logic [HEIGHT_W-1:0] cfg_height,
  output logic                cfg_err,
  input  logic                pix_valid,
  input  logic [7:0]          pix_data,
  output logic                pix_ready,
  output logic [7:0]          cur_p,
  output logic [2:0]          sel,
  output logic                stream_in,
  output logic                xout_rdy,
  input  logic                dn_ready,
  output logic                out_valid,
  output logic                out_eol,
  output logic                busy,
  output logic                frame_done
);

  localparam logic [2:0] MAX_F = 3'(MAX_FACTOR);

  state_e                      state_q, state_d;
  logic [2:0]                  factor_q, factor_d;
  logic [WIDTH_W-1:0]          width_q, width_d;
  logic [HEIGHT_W-1:0]         height_q, height_d;
  logic [FIR_MAX_FACTOR_W-1:0] phase_q, phase_d;
  logic                        grp_eol_q, grp_eol_d;
  logic                        grp_last_q, grp_last_d;
  logic                        out_valid_q, out_valid_d;
  logic                        out_eol_q, out_eol_d;
  logic                        out_last_q, out_last_d;
  logic                        cfg_err_q, cfg_err_d;

  logic cfg_ok, beat, grp_done, hs, cnt_clr, col_last, line_last;

  line_counter #(
    .WIDTH_W  (WIDTH_W),
    .HEIGHT_W (HEIGHT_W)
  ) u_line_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .adv       (beat),
    .width     (width_q),
    .height    (height_q),
    .col_last  (col_last),
    .line_last (line_last)
  );

  // Next-state logic: config capture, group accumulation and output handshake
  always_comb begin
    cfg_ok   = (cfg_factor != 3'd0) && (cfg_factor <= MAX_F) &&
               (cfg_width != '0) && (cfg_height != '0);
    beat     = (state_q == ST_ACCUM) && pix_valid;
    grp_done = beat && ((phase_q == factor_q - 3'd1) || col_last);
    hs       = out_valid_q && dn_ready;

    state_d    = state_q;
    factor_d   = factor_q;
    width_d    = width_q;
    height_d   = height_q;
    phase_d    = phase_q;
    grp_eol_d  = grp_eol_q;
    grp_last_d = grp_last_q;
    out_eol_d  = out_eol_q;
    out_last_d = out_last_q;
    cfg_err_d  = 1'b0;
    cnt_clr    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          if (cfg_ok) begin
            factor_d   = cfg_factor;
            width_d    = cfg_width;
            height_d   = cfg_height;
            grp_last_d = 1'b0;
            cnt_clr    = 1'b1;
            state_d    = ST_CLEAR;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_ACCUM: begin
        if (beat) begin
          phase_d = phase_q + 3'd1;
        end
        if (grp_done) begin
          grp_eol_d  = col_last;
          grp_last_d = col_last && line_last;
          // The output latch may only be overwritten once its value is taken
          state_d    = (!out_valid_q || dn_ready) ? ST_EMIT : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!out_valid_q || dn_ready) begin
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        out_eol_d  = grp_eol_q;
        out_last_d = grp_last_q;
        state_d    = ST_CLEAR;
      end
      ST_CLEAR: begin
        // Zeroing the phase registers here also pads a partial line-end group
        phase_d = '0;
        state_d = grp_last_q ? ST_IDLE : ST_ACCUM;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new result landing wins over the handshake that retires the old one
    if (state_q == ST_EMIT) begin
      out_valid_d = 1'b1;
    end else if (hs) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      factor_q    <= '0;
      width_q     <= '0;
      height_q    <= '0;
      phase_q     <= '0;
      grp_eol_q   <= 1'b0;
      grp_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_eol_q   <= 1'b0;
      out_last_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      factor_q    <= factor_d;
      width_q     <= width_d;
      height_q    <= height_d;
      phase_q     <= phase_d;
      grp_eol_q   <= grp_eol_d;
      grp_last_q  <= grp_last_d;
      out_valid_q <= out_valid_d;
      out_eol_q   <= out_eol_d;
      out_last_q  <= out_last_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Output decode from state; everything idles at zero
  always_comb begin
    pix_ready  = (state_q == ST_ACCUM);
    cur_p      = (state_q == ST_ACCUM) ? pix_data : 8'd0;
    sel        = (state_q == ST_ACCUM) ? phase_q : 3'd0;
    stream_in  = (state_q == ST_ACCUM) || (state_q == ST_HOLD) ||
                 (state_q == ST_EMIT);
    xout_rdy   = (state_q == ST_EMIT);
    out_valid  = out_valid_q;
    out_eol    = out_valid_q && out_eol_q;
    busy       = (state_q != ST_IDLE);
    frame_done = hs && out_last_q;
    cfg_err    = cfg_err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_x_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_fir_x_scheduler
// Brief   : Self-checking bench for fir_x_scheduler.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fir_x_scheduler;

  localparam int WW = 12;
  localparam int HW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [2:0]    cfg_factor = '0;
  logic [WW-1:0] cfg_width = '0;
  logic [HW-1:0] cfg_height = '0;
  logic          cfg_err;
  logic          pix_valid = 1'b0;
  logic [7:0]    pix_data = '0;
  logic          pix_ready;
  logic [7:0]    cur_p;
  logic [2:0]    sel;
  logic          stream_in, xout_rdy;
  logic          dn_ready = 1'b0;
  logic          out_valid, out_eol, busy, frame_done;

  int tests = 0;
  int fails = 0;

  fir_x_scheduler #(.MAX_FACTOR(7), .WIDTH_W(WW), .HEIGHT_W(HW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_factor(cfg_factor),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_err(cfg_err),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .cur_p(cur_p), .sel(sel), .stream_in(stream_in), .xout_rdy(xout_rdy),
    .dn_ready(dn_ready), .out_valid(out_valid), .out_eol(out_eol),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_cfg(input int f, input int w, input int h);
    @(posedge clk); #1;
    cfg_valid  = 1'b1;
    cfg_factor = 3'(f);
    cfg_width  = WW'(w);
    cfg_height = HW'(h);
    @(posedge clk); #1;
    cfg_valid  = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    logic [23:0] v;
    v = {pix_ready, cur_p, sel, stream_in, xout_rdy, out_valid, out_eol,
         busy, frame_done, cfg_err, 3'b000};
    tests++;
    if (v !== 24'd0) begin
      fails++;
      $display("FAIL %s: outputs got %h expected 0", name, v);
    end
  endtask

  task automatic test_reset();
    pix_valid = 1'b1;
    pix_data  = 8'hA5;
    dn_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_outputs");
    pix_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("after_reset_idle");
  endtask

  // Rejection table followed by an accepted factor-7 config
  task automatic test_cfg();
    int tf[5] = '{0, 8, 3, 3, 7};
    int tw[5] = '{6, 6, 0, 6, 14};
    int th[5] = '{1, 1, 1, 0, 1};
    bit te[5] = '{1, 1, 1, 1, 0};
    for (int i = 0; i < 5; i++) begin
      do_cfg(tf[i], tw[i], th[i]);
      @(negedge clk);
      tests++;
      if (cfg_err !== te[i]) begin
        fails++;
        $display("FAIL cfg_err[%0d]: got %b expected %b", i, cfg_err, te[i]);
      end
      tests++;
      if (busy !== !te[i]) begin
        fails++;
        $display("FAIL cfg_busy[%0d]: got %b expected %b", i, busy, !te[i]);
      end
    end
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_factor = 3'd0;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (cfg_err !== 1'b0) begin
      fails++;
      $display("FAIL cfg_ignored_when_busy: got %b expected 0", cfg_err);
    end
    apply_reset();
  endtask

  // Full frame against a model of groups, sels and end-of-line flags
  task automatic run_frame(input int d, input int w, input int h,
                           input int pv_pct, input int dr_pct, input bit timing);
    int exp_sel[$];
    int exp_grp[$];
    bit exp_eol[$];
    bit exp_last[$];
    int exp_emit[$];
    bit pend_eol[$];
    bit pend_last[$];
    int beats = 0, k = 0, t = 0, cyc = 0, s = 0, g = 0;
    bit started = 0, prev_x = 0, done = 0, e = 0, l = 0;
    for (int ln = 0; ln < h; ln++) begin
      for (int c = 0; c < w; c++) exp_sel.push_back(c % d);
      for (int c = 0; c < w; c += d) begin
        g = (w - c < d) ? (w - c) : d;
        exp_grp.push_back(g);
        exp_eol.push_back(c + g == w);
        exp_last.push_back((c + g == w) && (ln == h - 1));
        t += g;
        exp_emit.push_back(t);
        t += 2;
      end
    end
    do_cfg(d, w, h);
    while (!done && cyc < 20000) begin
      pix_valid = ($urandom_range(99) < pv_pct);
      pix_data  = 8'($urandom);
      dn_ready  = ($urandom_range(99) < dr_pct);
      @(negedge clk);
      if (pix_valid && pix_ready) begin
        started = 1;
        tests++;
        if (exp_sel.size() == 0) begin
          fails++;
          $display("FAIL extra_beat: got beat with sel %0d expected none", sel);
        end else begin
          s = exp_sel.pop_front();
          if (sel !== 3'(s)) begin
            fails++;
            $display("FAIL sel: got %0d expected %0d (D=%0d)", sel, s, d);
          end
        end
        tests++;
        if (cur_p !== pix_data) begin
          fails++;
          $display("FAIL cur_p: got %h expected %h", cur_p, pix_data);
        end
        beats++;
      end
      if (xout_rdy) begin
        tests++;
        if (prev_x) begin
          fails++;
          $display("FAIL xout_back_to_back: got 1 expected 0");
        end
        tests++;
        if (exp_grp.size() == 0) begin
          fails++;
          $display("FAIL extra_group: got %0d beats expected no group", beats);
        end else begin
          g = exp_grp.pop_front();
          if (beats != g) begin
            fails++;
            $display("FAIL group_size: got %0d expected %0d", beats, g);
          end
          pend_eol.push_back(exp_eol.pop_front());
          pend_last.push_back(exp_last.pop_front());
          t = exp_emit.pop_front();
          if (timing) begin
            tests++;
            if (k != t) begin
              fails++;
              $display("FAIL xout_cycle: got %0d expected %0d", k, t);
            end
          end
        end
        beats = 0;
      end
      prev_x = xout_rdy;
      if (out_valid && dn_ready) begin
        e = 0; l = 0;
        if (pend_eol.size() != 0) begin
          e = pend_eol.pop_front();
          l = pend_last.pop_front();
        end
        tests++;
        if (out_eol !== e) begin
          fails++;
          $display("FAIL out_eol: got %b expected %b", out_eol, e);
        end
        tests++;
        if (frame_done !== l) begin
          fails++;
          $display("FAIL frame_done: got %b expected %b", frame_done, l);
        end
        if (l) done = 1;
      end else if (frame_done) begin
        tests++;
        fails++;
        $display("FAIL frame_done_spurious: got 1 expected 0");
      end
      if (started) k++;
      cyc++;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL frame_timeout: got no frame_done expected one (D=%0d W=%0d H=%0d)", d, w, h);
    end
    tests++;
    if (exp_sel.size() != 0) begin
      fails++;
      $display("FAIL beats_left: got %0d unconsumed expected 0", exp_sel.size());
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL end_idle: got busy=%b out_valid=%b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_hold();
    int cyc = 0;
    bit seen = 0;
    do_cfg(2, 4, 1);
    pix_valid = 1'b1;
    dn_ready  = 1'b0;
    @(negedge clk);
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || xout_rdy !== 1'b0) begin
        fails++;
        $display("FAIL hold_wait[%0d]: got out_valid=%b xout_rdy=%b expected 1 0", i, out_valid, xout_rdy);
      end
    end
    tests++;
    if (pix_ready !== 1'b0 || busy !== 1'b1 || stream_in !== 1'b1) begin
      fails++;
      $display("FAIL hold_state: got ready=%b busy=%b stream=%b expected 0 1 1", pix_ready, busy, stream_in);
    end
    @(posedge clk); #1;
    dn_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (xout_rdy !== 1'b0 || frame_done !== 1'b0) begin
      fails++;
      $display("FAIL hold_release: got xout=%b fd=%b expected 0 0", xout_rdy, frame_done);
    end
    @(negedge clk);
    tests++;
    if (xout_rdy !== 1'b1) begin
      fails++;
      $display("FAIL hold_emit: got %b expected 1", xout_rdy);
    end
    cyc = 0;
    while (!seen && cyc < 50) begin
      @(negedge clk);
      seen = frame_done;
      cyc++;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL hold_frame_done: got 0 expected 1");
    end
    pix_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int acc = 0, cyc = 0;
    do_cfg(5, 10, 1);
    pix_valid = 1'b1;
    dn_ready  = 1'b1;
    while (acc < 3 && cyc < 50) begin
      @(negedge clk);
      if (pix_valid && pix_ready) acc++;
      cyc++;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || frame_done !== 1'b0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL post_reset[%0d]: got busy=%b fd=%b ov=%b expected 0 0 0", i, busy, frame_done, out_valid);
      end
    end
    pix_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cfg();
    run_frame(3, 6, 1, 100, 100, 1);
    run_frame(4, 6, 1, 100, 100, 1);
    run_frame(1, 4, 2, 100, 100, 1);
    run_frame(7, 7, 2, 100, 100, 1);
    test_hold();
    for (int i = 0; i < 8; i++) begin
      run_frame($urandom_range(7, 1), $urandom_range(20, 1), $urandom_range(3, 1), 70, 60, 0);
    end
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
